// File: rtl/bin2qdi_feeder_if.sv
// Write-side and channel-side signals of the binary-to-QDI token feeder.
// The master modport is the feeder; the slave modport is the environment and source stage.
interface bin2qdi_feeder_if #(
  parameter int unsigned DW = 1
) ();
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic          empty;
  logic [DW-1:0] din;
  logic          req;
  logic          R_mon;
  logic          Re_mon;

  modport master (
    input  wr_en, wr_data, R_mon, Re_mon,
    output full, empty, din, req
  );

  modport slave (
    output wr_en, wr_data, R_mon, Re_mon,
    input  full, empty, din, req
  );
endinterface

// File: rtl/bin2qdi_feeder.sv
// Clocked token feeder for the e1of1 binary-to-QDI source: FIFO, four-phase req sequencer, counter.
// Optional handshake watchdog (timeout_err, TMO) is built when FEEDER_WATCHDOG_EN is defined.
module bin2qdi_feeder #(
  parameter int unsigned DW  = 1,
  parameter int unsigned AW  = 2,
  parameter int unsigned CW  = 16,
  parameter int unsigned GAP = 1
`ifdef FEEDER_WATCHDOG_EN
  ,
  parameter int unsigned TMO = 255
`endif
) (
  input  logic                   CLK,
  input  logic                   RESETn,
  bin2qdi_feeder_if.master       chan,
  output logic                   busy,
  output logic [CW-1:0]          tok_cnt
`ifdef FEEDER_WATCHDOG_EN
  ,
  output logic                   timeout_err
`endif
);

  localparam int unsigned Depth = 2 ** AW;
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned GW    = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StAck, StGap} state_e;

  state_e        state;
  logic [DW-1:0] mem [Depth];
  logic [PW-1:0] wptr, rptr;
  logic          full, empty, wr_ok, pop;
  logic          r_s1, r_s, re_s1, re_s;
  logic          req_q, busy_q;
  logic [DW-1:0] din_q;
  logic [CW-1:0] tok_q;
  logic [GW-1:0] gap_q;

  // MSB differs with equal index bits: writer has lapped the reader
  assign full  = (wptr[PW-1] != rptr[PW-1]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign wr_ok = chan.wr_en && !full;
  assign pop   = (state == StIdle) && !empty && !r_s && re_s;

  assign chan.full  = full;
  assign chan.empty = empty;
  assign chan.din   = din_q;
  assign chan.req   = req_q;
  assign busy       = busy_q;
  assign tok_cnt    = tok_q;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_s1  <= 1'b0;
      r_s   <= 1'b0;
      re_s1 <= 1'b0;
      re_s  <= 1'b0;
    end else begin
      r_s1  <= chan.R_mon;
      r_s   <= r_s1;
      re_s1 <= chan.Re_mon;
      re_s  <= re_s1;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_ok) mem[wptr[AW-1:0]] <= chan.wr_data;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + PW'(1);
      if (pop)   rptr <= rptr + PW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state  <= StIdle;
      req_q  <= 1'b0;
      busy_q <= 1'b0;
      din_q  <= '0;
      tok_q  <= '0;
      gap_q  <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (pop) begin
            din_q  <= mem[rptr[AW-1:0]];
            req_q  <= 1'b1;
            busy_q <= 1'b1;
            state  <= StReq;
          end
        end
        StReq: begin
          if (r_s) begin
            req_q <= 1'b0;
            state <= StAck;
          end
        end
        StAck: begin
          if (!r_s) begin
            tok_q <= tok_q + CW'(1);
            gap_q <= GW'(GAP);
            state <= StGap;
          end
        end
        StGap: begin
          // Counter runs down to zero, so the gap state lasts GAP+1 cycles
          if (gap_q == '0) begin
            busy_q <= 1'b0;
            state  <= StIdle;
          end else begin
            gap_q <= gap_q - GW'(1);
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

`ifdef FEEDER_WATCHDOG_EN
  logic        state_chg;
  logic [31:0] wd_cnt;
  logic        to_q;

  always_comb begin
    state_chg = 1'b0;
    unique case (state)
      StIdle:  state_chg = pop;
      StReq:   state_chg = r_s;
      StAck:   state_chg = !r_s;
      StGap:   state_chg = (gap_q == '0);
      default: state_chg = 1'b1;
    endcase
  end

  // Fires when the edge closing cycle TMO of a REQ/ACK stay leaves the FSM still there
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wd_cnt <= '0;
      to_q   <= 1'b0;
    end else begin
      if (state_chg) begin
        wd_cnt <= '0;
      end else if (wd_cnt < TMO) begin
        wd_cnt <= wd_cnt + 32'd1;
      end
      if (!state_chg && (state == StReq || state == StAck) && (wd_cnt + 32'd1 >= TMO)) begin
        to_q <= 1'b1;
      end
    end
  end

  assign timeout_err = to_q;
`endif

endmodule

// File: tb/tb_bin2qdi_feeder.sv
// Directed bench for bin2qdi_feeder: token-order scoreboard, cycle-exact token counter model,
// and literal checks of latency, gap timing, FIFO limits, reset and (if built) the watchdog.
module tb_bin2qdi_feeder;

  localparam int unsigned TB_GAP = 3;
  localparam int          DEPTH  = 4;

  logic        clk;
  logic        rst_n;
  logic        busy;
  logic [15:0] tok_cnt;
`ifdef FEEDER_WATCHDOG_EN
  logic        timeout_err;
`endif

  bin2qdi_feeder_if #(.DW(1)) bus ();

  bin2qdi_feeder #(
    .DW (1),
    .AW (2),
    .CW (16),
    .GAP(TB_GAP)
`ifdef FEEDER_WATCHDOG_EN
    ,
    .TMO(20)
`endif
  ) dut (
    .CLK    (clk),
    .RESETn (rst_n),
    .chan   (bus),
    .busy   (busy),
    .tok_cnt(tok_cnt)
`ifdef FEEDER_WATCHDOG_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          gen = 0;
  logic        stall;
  logic        r_hold;
  logic        re_chan;
  logic [0:0]  mq[$];
  logic [0:0]  dlog[$];
  int          rise_log[$];
  int          fall_log[$];
  int          fall_idx = 0;
  logic [15:0] exp_tok;
  logic        prev_req;
  logic [0:0]  held_din;

  assign bus.Re_mon = re_chan & ~stall;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [0:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (!(!busy && bus.empty) && n < 500) begin
      tick();
      n++;
    end
    chk({nm, "_idle_bound"}, 32'(n < 500), 1);
  endtask

  // Source stage / channel: R rises 5 cycles after req, Re drops, R resets, Re returns
  initial begin : chan_model
    int g;
    bus.R_mon = 1'b0;
    re_chan   = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.req && rst_n) begin
        g = gen;
        repeat (5) @(posedge clk);
        #1;
        if (g == gen && !r_hold) begin
          bus.R_mon = 1'b1;
          repeat (2) @(posedge clk);
          #1 re_chan = 1'b0;
          @(posedge clk);
          #1 bus.R_mon = 1'b0;
          fall_log.push_back(cyc);
          @(posedge clk);
          #1 re_chan = 1'b1;
        end
      end
    end
  end

  // Reference model updates on the rising edge; DUT compared on the falling edge
  initial begin : scoreboard
    exp_tok  = '0;
    prev_req = 1'b0;
    held_din = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        mq.delete();
        exp_tok  = '0;
        fall_idx = fall_log.size();
        prev_req = 1'b0;
      end else begin
        if (bus.wr_en && mq.size() < DEPTH) mq.push_back(bus.wr_data);
        // Two synchroniser flops plus the ACK decision edge after R falls
        while (fall_idx < fall_log.size() && fall_log[fall_idx] + 3 <= cyc) begin
          exp_tok = exp_tok + 16'd1;
          fall_idx++;
        end
      end
      @(negedge clk);
      if (rst_n) begin
        if (bus.req && !prev_req) begin
          rise_log.push_back(cyc);
          if (mq.size() == 0) begin
            chk("req_without_token", 32'(bus.req), 0);
          end else begin
            chk("din_at_req", 32'(bus.din), 32'(mq[0]));
            dlog.push_back(bus.din);
            void'(mq.pop_front());
          end
          held_din = bus.din;
        end else if (bus.req) begin
          chk("din_stable", 32'(bus.din), 32'(held_din));
        end
        chk("empty", 32'(bus.empty), 32'(mq.size() == 0));
        chk("full", 32'(bus.full), 32'(mq.size() == DEPTH));
        chk("tok_cnt", 32'(tok_cnt), 32'(exp_tok));
        prev_req = bus.req;
      end
    end
  end

  initial begin : stimulus
    int stamp;
    int k;
    int n;
    rst_n       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    stall       = 1'b0;
    r_hold      = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_din", 32'(bus.din), 0);
    chk("rst_req", 32'(bus.req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tok", 32'(tok_cnt), 0);
`ifdef FEEDER_WATCHDOG_EN
    chk("rst_timeout", 32'(timeout_err), 0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) tick();

    // Three tokens back to back
    @(posedge clk);
    #1;
    stamp = cyc;
    push(1'b1);
    push(1'b0);
    push(1'b1);
    wait_idle("a");
    chk("a_tok", 32'(tok_cnt), 3);
    chk("a_empty", 32'(bus.empty), 1);
    chk("a_busy", 32'(busy), 0);
    chk("a_pulses", 32'(rise_log.size()), 3);
    chk("a_din0", 32'(dlog[0]), 1);
    chk("a_din1", 32'(dlog[1]), 0);
    chk("a_din2", 32'(dlog[2]), 1);
    chk("a_latency", 32'(rise_log[0] - stamp), 2);
    chk("a_gap1", 32'(rise_log[1] - fall_log[0]), 8);
    chk("a_gap2", 32'(rise_log[2] - fall_log[1]), 8);

    // Channel stalled: fill the FIFO, overflow write dropped
    stall = 1'b1;
    repeat (3) tick();
    @(posedge clk);
    #1;
    k = rise_log.size();
    push(1'b1);
    push(1'b0);
    push(1'b0);
    push(1'b1);
    chk("b_full4", 32'(bus.full), 1);
    push(1'b1);
    chk("b_full5", 32'(bus.full), 1);
    repeat (4) tick();
    chk("b_no_req", 32'(rise_log.size() - k), 0);
    stall = 1'b0;
    wait_idle("b");
    chk("b_tok", 32'(tok_cnt), 7);
    chk("b_pulses", 32'(rise_log.size() - k), 4);
    chk("b_din0", 32'(dlog[3]), 1);
    chk("b_din1", 32'(dlog[4]), 0);
    chk("b_din2", 32'(dlog[5]), 0);
    chk("b_din3", 32'(dlog[6]), 1);

    // Pointer wrap across many rounds
    for (int r = 0; r < 10; r++) begin
      @(posedge clk);
      #1;
      push(1'(r % 2));
      push(1'b1);
      push(1'((r / 2) % 2));
      wait_idle("w");
    end
    chk("w_tok", 32'(tok_cnt), 37);
    chk("w_delivered", 32'(dlog.size()), 37);

    // Reset in the middle of a request
    @(posedge clk);
    #1;
    k = rise_log.size();
    push(1'b1);
    n = 0;
    while (rise_log.size() == k && n < 20) begin
      tick();
      n++;
    end
    chk("r_req_seen", 32'(bus.req), 1);
    rst_n = 1'b0;
    gen++;
    #1;
    chk("r_req", 32'(bus.req), 0);
    chk("r_tok", 32'(tok_cnt), 0);
    chk("r_empty", 32'(bus.empty), 1);
    chk("r_busy", 32'(busy), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    k = rise_log.size();
    repeat (10) tick();
    chk("r_no_req", 32'(rise_log.size() - k), 0);
    @(posedge clk);
    #1;
    push(1'b0);
    wait_idle("r");
    chk("r_tok_after", 32'(tok_cnt), 1);

`ifdef FEEDER_WATCHDOG_EN
    // Channel never answers: watchdog latches in cycle 21 of REQ
    r_hold = 1'b1;
    @(posedge clk);
    #1;
    k = rise_log.size();
    push(1'b1);
    n = 0;
    while (rise_log.size() == k && n < 20) begin
      tick();
      n++;
    end
    stamp = rise_log[$];
    while (cyc < stamp + 19) tick();
    chk("wd_early", 32'(timeout_err), 0);
    tick();
    chk("wd_fire", 32'(timeout_err), 1);
    chk("wd_req_held", 32'(bus.req), 1);
    repeat (5) tick();
    chk("wd_latched", 32'(timeout_err), 1);
    rst_n = 1'b0;
    gen++;
    r_hold = 1'b0;
    #1;
    chk("wd_clear", 32'(timeout_err), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
